// File: rtl/nn_pkg.sv
// Shared definitions for the perceptron load sequencer: stream widths, layer shape,
// parameter sub-index layout within a neuron, and the sequencer state encoding.
package nn_pkg;

    localparam int DATA_W    = 8;
    localparam int N_NEURONS = 4;
    localparam int N_INPUTS  = 4;
    localparam int CNT_W     = 5;
    localparam int IDX_W     = 2;

    // Byte order of one neuron's parameter block; index = neuron*PRM_PER_NRN + k.
    typedef enum logic [2:0] {
        K_W0 = 3'd0,
        K_W1 = 3'd1,
        K_W2 = 3'd2,
        K_W3 = 3'd3,
        K_B  = 3'd4,
        K_TH = 3'd5
    } prm_k_e;

    localparam int PRM_PER_NRN = int'(K_TH) + 1;
    localparam int N_PRM       = N_NEURONS * PRM_PER_NRN;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_PRM = 3'd1,
        ST_LOAD_INP = 3'd2,
        ST_EVAL     = 3'd3,
        ST_EMIT     = 3'd4
    } state_e;

endpackage

// File: rtl/nn_result_buf.sv
// Snapshot of the four neuron outputs plus the read index used while results
// are emitted; later changes on nrn_in are invisible until the next snap.
module nn_result_buf
    import nn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        snap,
    input  logic                        clr,
    input  logic                        adv,
    input  logic [N_NEURONS*DATA_W-1:0] nrn_in,
    output logic [DATA_W-1:0]           rd_data,
    output logic [IDX_W-1:0]            rd_idx
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

    logic [DATA_W-1:0] res_buf_q [N_NEURONS];
    logic [DATA_W-1:0] res_buf_d [N_NEURONS];
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;

    always_comb begin
        res_buf_d = res_buf_q;
        idx_d     = idx_q;
        if (snap) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                res_buf_d[i] = nrn_in[i*DATA_W +: DATA_W];
            end
        end
        if (clr) begin
            idx_d = '0;
        end else if (adv) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                res_buf_q[i] <= '0;
            end
            idx_q <= '0;
        end else begin
            res_buf_q <= res_buf_d;
            idx_q     <= idx_d;
        end
    end

    assign rd_data = res_buf_q[idx_q];
    assign rd_idx  = idx_q;

endmodule

// File: rtl/nn_load_sequencer.sv
// Steers one valid/ready byte stream into the parameter bank and the input
// registers, waits for the layer to settle, then emits the four neuron results.
module nn_load_sequencer
    import nn_pkg::*;
#(
    parameter int EVAL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        prm_we,
    output logic [4:0]  prm_addr,
    output logic [7:0]  prm_wdata,
    output logic        inp_we,
    output logic [1:0]  inp_addr,
    output logic [7:0]  inp_wdata,
    input  logic [31:0] nrn_out,
    output logic [7:0]  res_data,
    output logic [1:0]  res_idx,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        params_loaded,
    output logic [2:0]  state_o
);

    localparam int EV_W = 2;
    localparam logic [CNT_W-1:0] PRM_LAST = CNT_W'(N_PRM - 1);
    localparam logic [CNT_W-1:0] INP_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic [EV_W-1:0]  EV_INIT  = EV_W'(EVAL_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EV_W-1:0]   ev_q, ev_d;
    logic              params_loaded_q, params_loaded_d;
    logic              prm_we_q, prm_we_d;
    logic [4:0]        prm_addr_q, prm_addr_d;
    logic [7:0]        prm_wdata_q, prm_wdata_d;
    logic              inp_we_q, inp_we_d;
    logic [1:0]        inp_addr_q, inp_addr_d;
    logic [7:0]        inp_wdata_q, inp_wdata_d;
    logic              accept;
    logic              res_hs;
    logic              snap;

    assign in_ready  = ((state_q == ST_LOAD_PRM) || (state_q == ST_LOAD_INP)) && !load_req;
    assign accept    = in_valid && in_ready;
    assign res_valid = (state_q == ST_EMIT);
    assign res_hs    = res_valid && res_ready;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ev_d            = ev_q;
        params_loaded_d = params_loaded_q;
        prm_we_d        = 1'b0;
        prm_addr_d      = prm_addr_q;
        prm_wdata_d     = prm_wdata_q;
        inp_we_d        = 1'b0;
        inp_addr_d      = inp_addr_q;
        inp_wdata_d     = inp_wdata_q;
        snap            = 1'b0;
        if (load_req) begin
            state_d         = ST_LOAD_PRM;
            cnt_d           = '0;
            ev_d            = '0;
            params_loaded_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_PRM: begin
                    if (accept) begin
                        prm_we_d    = 1'b1;
                        prm_addr_d  = cnt_q;
                        prm_wdata_d = in_data;
                        if (cnt_q == PRM_LAST) begin
                            params_loaded_d = 1'b1;
                            cnt_d           = '0;
                            state_d         = ST_LOAD_INP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_INP: begin
                    if (accept) begin
                        inp_we_d    = 1'b1;
                        inp_addr_d  = cnt_q[1:0];
                        inp_wdata_d = in_data;
                        if (cnt_q == INP_LAST) begin
                            cnt_d   = '0;
                            ev_d    = EV_INIT;
                            state_d = ST_EVAL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    // Settle time is counted from the cycle the last input write lands.
                    if (!inp_we_q) begin
                        if (ev_q == EV_W'(1)) begin
                            snap    = 1'b1;
                            ev_d    = '0;
                            state_d = ST_EMIT;
                        end else begin
                            ev_d = ev_q - 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (res_hs && (res_idx == IDX_LAST)) begin
                        state_d = ST_LOAD_INP;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            ev_q            <= '0;
            params_loaded_q <= 1'b0;
            prm_we_q        <= 1'b0;
            prm_addr_q      <= '0;
            prm_wdata_q     <= '0;
            inp_we_q        <= 1'b0;
            inp_addr_q      <= '0;
            inp_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ev_q            <= ev_d;
            params_loaded_q <= params_loaded_d;
            prm_we_q        <= prm_we_d;
            prm_addr_q      <= prm_addr_d;
            prm_wdata_q     <= prm_wdata_d;
            inp_we_q        <= inp_we_d;
            inp_addr_q      <= inp_addr_d;
            inp_wdata_q     <= inp_wdata_d;
        end
    end

    nn_result_buf u_result_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .snap    (snap),
        .clr     (load_req),
        .adv     (res_hs),
        .nrn_in  (nrn_out),
        .rd_data (res_data),
        .rd_idx  (res_idx)
    );

    assign prm_we        = prm_we_q;
    assign prm_addr      = prm_addr_q;
    assign prm_wdata     = prm_wdata_q;
    assign inp_we        = inp_we_q;
    assign inp_addr      = inp_addr_q;
    assign inp_wdata     = inp_wdata_q;
    assign params_loaded = params_loaded_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Bench for nn_load_sequencer: directed scenarios followed by randomized
// parameter loads and inferences, checked against expected write and result queues.
module tb_nn_load_sequencer;

    localparam int EVAL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        prm_we;
    logic [4:0]  prm_addr;
    logic [7:0]  prm_wdata;
    logic        inp_we;
    logic [1:0]  inp_addr;
    logic [7:0]  inp_wdata;
    logic [31:0] nrn_out = '0;
    logic [7:0]  res_data;
    logic [1:0]  res_idx;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        params_loaded;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [12:0] exp_prm_q[$];
    logic [9:0]  exp_inp_q[$];

    nn_load_sequencer #(.EVAL_CYCLES(EVAL_CYCLES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_req      (load_req),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .prm_we        (prm_we),
        .prm_addr      (prm_addr),
        .prm_wdata     (prm_wdata),
        .inp_we        (inp_we),
        .inp_addr      (inp_addr),
        .inp_wdata     (inp_wdata),
        .nrn_out       (nrn_out),
        .res_data      (res_data),
        .res_idx       (res_idx),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .params_loaded (params_loaded),
        .state_o       (state_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (rst_n) begin
            if (prm_we) begin
                if (exp_prm_q.size() == 0) check("prm_unexpected", {prm_addr, prm_wdata}, 13'h0);
                else check("prm_write", {prm_addr, prm_wdata}, exp_prm_q.pop_front());
            end
            if (inp_we) begin
                if (exp_inp_q.size() == 0) check("inp_unexpected", {inp_addr, inp_wdata}, 10'h0);
                else check("inp_write", {inp_addr, inp_wdata}, exp_inp_q.pop_front());
            end
        end
    end

    // Drivers: all start and end at #1 after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", in_ready, 1);
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_prm(input logic [7:0] b, input logic [4:0] addr);
        int acc;
        exp_prm_q.push_back({addr, b});
        send_byte(b, acc);
    endtask

    task automatic send_inp(input logic [7:0] b, input logic [1:0] addr, output int acc);
        exp_inp_q.push_back({addr, b});
        send_byte(b, acc);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_timeout", res_valid, 1);
    endtask

    task automatic take_res(input logic [7:0] ed, input logic [1:0] ei, input int stall);
        wait_res_valid();
        repeat (stall) @(negedge clk);
        check("res_data", res_data, ed);
        check("res_idx", res_idx, ei);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int acc;
        int n_seen;
        logic [31:0] v;
        logic [7:0] exp_b [4];

        // 1. reset with in_valid held high
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_state", state_o, 0);
        check("rst_params_loaded", params_loaded, 0);
        check("rst_prm_we", prm_we, 0);
        check("rst_inp_we", inp_we, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", {res_idx, res_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            check("idle_state", state_o, 0);
        end
        tick();
        in_valid = 1'b0;

        // 2. parameter load 0x00..0x17, continuous valid
        load_req = 1'b1;
        @(negedge clk);
        check("load_req_in_ready", in_ready, 0);
        tick();
        load_req = 1'b0;
        check("prm_state", state_o, 1);
        for (int k = 0; k < 24; k++) begin
            send_prm(8'(k), 5'(k));
            if (k == 22) check("params_loaded_early", params_loaded, 0);
        end
        check("params_loaded", params_loaded, 1);
        check("inp_state", state_o, 2);

        // 3. inputs, latency and in-order results
        nrn_out = 32'h04030201;
        send_inp(8'h11, 2'd0, acc);
        send_inp(8'h22, 2'd1, acc);
        send_inp(8'h33, 2'd2, acc);
        send_inp(8'h44, 2'd3, acc);
        @(negedge clk);
        check("eval_state", state_o, 3);
        check("eval_in_ready", in_ready, 0);
        n_seen = 0;
        while (!res_valid && n_seen < 50) begin
            @(negedge clk);
            n_seen++;
        end
        check("res_latency", cyc - acc, EVAL_CYCLES + 2);
        tick();
        take_res(8'h01, 2'd0, 0);

        // 4. backpressure at idx 1 and snapshot isolation
        wait_res_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_data", res_data, 8'h02);
            check("stall_idx", res_idx, 2'd1);
            if (i == 2) nrn_out = 32'hFFFFFFFF;
            @(negedge clk);
        end
        tick();
        take_res(8'h02, 2'd1, 0);
        take_res(8'h03, 2'd2, 0);
        take_res(8'h04, 2'd3, 0);
        @(negedge clk);
        check("emit_done_valid", res_valid, 0);
        check("emit_done_state", state_o, 2);
        tick();

        // 5. reload interrupted after 10 bytes, concurrent valid ignored
        pulse_load();
        for (int k = 0; k < 10; k++) send_prm(8'($urandom), 5'(k));
        load_req = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        check("reload_in_ready", in_ready, 0);
        tick();
        load_req = 1'b0;
        in_valid = 1'b0;
        check("reload_state", state_o, 1);
        check("reload_params_loaded", params_loaded, 0);
        for (int k = 0; k < 24; k++) begin
            send_prm(8'($urandom), 5'(k));
            if (k == 22) check("reload_loaded_early", params_loaded, 0);
        end
        check("reload_params_done", params_loaded, 1);

        // 6. load_req during EMIT at idx 2
        v = $urandom;
        nrn_out = v;
        for (int i = 0; i < 4; i++) send_inp(8'($urandom), 2'(i), acc);
        take_res(v[7:0], 2'd0, 0);
        take_res(v[15:8], 2'd1, 0);
        wait_res_valid();
        check("abort_idx", res_idx, 2'd2);
        tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("abort_res_valid", res_valid, 0);
        check("abort_state", state_o, 1);
        n_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) n_seen++;
        end
        check("abort_no_results", n_seen, 0);
        tick();
        res_ready = 1'b0;

        // Randomized: gapped parameter load, then inferences
        for (int k = 0; k < 24; k++) begin
            gap($urandom_range(0, 2));
            send_prm(8'($urandom), 5'(k));
        end
        check("rand_params_loaded", params_loaded, 1);
        for (int t = 0; t < 20; t++) begin
            v = $urandom;
            nrn_out = v;
            for (int i = 0; i < 4; i++) exp_b[i] = v[8*i +: 8];
            for (int i = 0; i < 4; i++) begin
                gap($urandom_range(0, 3));
                send_inp(8'($urandom), 2'(i), acc);
            end
            for (int i = 0; i < 4; i++) begin
                take_res(exp_b[i], 2'(i), $urandom_range(0, 3));
                nrn_out = $urandom;
            end
        end

        gap(3);
        check("prm_queue_empty", exp_prm_q.size(), 0);
        check("inp_queue_empty", exp_inp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
